// File: rtl/irq_gateway_arbiter.sv
// ---------------------------------------------------------------------------
// irq_gateway_arbiter
//
// Purpose:
//   Turns synchronized level-sensitive interrupt lines into single pending
//   requests (one gateway per source), picks the highest-priority pending
//   source above a programmable threshold, and runs the claim/complete
//   handshake with the core. Each source has at most one request in flight.
//   Source IDs are 1..NUM_SRC; ID 0 means "none". 2**ID_W must exceed NUM_SRC.
//
// Ports:
//   i_clock        single clock for all state
//   i_reset        synchronous, active-high reset
//   i_irq_sync     synchronized interrupt levels, bit i is source ID i+1
//   i_src_prio     per-source priority, field i at [i*PRIO_W +: PRIO_W];
//                  priority 0 disables the source
//   i_threshold    only priorities strictly above this raise o_irq_out
//   i_claim        one-cycle claim strobe from the core
//   i_complete     one-cycle completion strobe
//   i_complete_id  ID being completed, valid while i_complete=1
//   o_irq_out      registered external-interrupt request
//   o_best_id      registered ID of the current winner, or 0
//   o_claim_id     ID returned by the most recent claim (held)
//   o_claim_valid  one-cycle pulse, one cycle after i_claim
// ---------------------------------------------------------------------------
module irq_gateway_arbiter #(
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned PRIO_W  = 2,
  parameter int unsigned ID_W    = 3
) (
  input  logic                        i_clock,
  input  logic                        i_reset,
  input  logic [NUM_SRC-1:0]          i_irq_sync,
  input  logic [NUM_SRC*PRIO_W-1:0]   i_src_prio,
  input  logic [PRIO_W-1:0]           i_threshold,
  input  logic                        i_claim,
  input  logic                        i_complete,
  input  logic [ID_W-1:0]             i_complete_id,
  output logic                        o_irq_out,
  output logic [ID_W-1:0]             o_best_id,
  output logic [ID_W-1:0]             o_claim_id,
  output logic                        o_claim_valid
);

  // Gateway states: waiting for a level, latched request, claimed by core.
  typedef enum logic [1:0] {
    GW_IDLE = 2'd0,
    GW_PEND = 2'd1,
    GW_INFL = 2'd2
  } gw_state_e;

  gw_state_e               r_gw_state     [NUM_SRC];
  gw_state_e               w_gw_state_nxt [NUM_SRC];
  logic [NUM_SRC-1:0]      w_pending;
  logic [PRIO_W-1:0]       w_prio         [NUM_SRC];

  logic [ID_W-1:0]         w_best_id;
  logic [PRIO_W-1:0]       w_best_prio;
  logic                    w_irq_out_nxt;

  logic                    r_irq_out;
  logic [ID_W-1:0]         r_best_id;
  logic [ID_W-1:0]         r_claim_id;
  logic                    r_claim_valid;

  // Unpack the flat priority bus into one field per source.
  always_comb begin
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      w_prio[i] = i_src_prio[i*PRIO_W +: PRIO_W];
    end
  end

  // Gateway state register.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      for (int i = 0; i < int'(NUM_SRC); i++) begin
        r_gw_state[i] <= GW_IDLE;
      end
    end else begin
      for (int i = 0; i < int'(NUM_SRC); i++) begin
        r_gw_state[i] <= w_gw_state_nxt[i];
      end
    end
  end

  // Gateway next-state logic. A source completing this cycle passes through
  // IDLE for one cycle before it can re-pend, and levels are ignored in INFL.
  always_comb begin
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      w_gw_state_nxt[i] = r_gw_state[i];
      case (r_gw_state[i])
        GW_IDLE: begin
          if (i_irq_sync[i]) begin
            w_gw_state_nxt[i] = GW_PEND;
          end
        end
        GW_PEND: begin
          if (i_claim && (w_best_id == ID_W'(i + 1))) begin
            w_gw_state_nxt[i] = GW_INFL;
          end
        end
        GW_INFL: begin
          if (i_complete && (i_complete_id == ID_W'(i + 1))) begin
            w_gw_state_nxt[i] = GW_IDLE;
          end
        end
        default: begin
          w_gw_state_nxt[i] = GW_IDLE;
        end
      endcase
    end
  end

  // Gateway output decode: which sources hold a latched request.
  always_comb begin
    w_pending = '0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      w_pending[i] = (r_gw_state[i] == GW_PEND);
    end
  end

  // Priority arbitration. Starting from priority 0 and accepting only a
  // strictly higher priority both excludes disabled sources and gives ties
  // to the lowest ID when scanning upward.
  always_comb begin
    w_best_id   = '0;
    w_best_prio = '0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      if (w_pending[i] && (w_prio[i] > w_best_prio)) begin
        w_best_id   = ID_W'(i + 1);
        w_best_prio = w_prio[i];
      end
    end
  end

  // Threshold only gates the interrupt line, never the claim result.
  assign w_irq_out_nxt = (w_best_id != '0) && (w_best_prio > i_threshold);

  // Registered arbitration result and claim response.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_irq_out     <= 1'b0;
      r_best_id     <= '0;
      r_claim_id    <= '0;
      r_claim_valid <= 1'b0;
    end else begin
      r_irq_out     <= w_irq_out_nxt;
      r_best_id     <= w_best_id;
      r_claim_valid <= i_claim;
      if (i_claim) begin
        r_claim_id <= w_best_id;
      end
    end
  end

  assign o_irq_out     = r_irq_out;
  assign o_best_id     = r_best_id;
  assign o_claim_id    = r_claim_id;
  assign o_claim_valid = r_claim_valid;

endmodule

// File: tb/tb_irq_gateway_arbiter.sv
// ---------------------------------------------------------------------------
// tb_irq_gateway_arbiter
//
// Purpose:
//   Drives directed and random traffic into irq_gateway_arbiter. Each cycle a
//   behavioural model (per-source pending/in-flight flags plus a priority
//   search) predicts the registered outputs; predictions are queued and a
//   separate monitor compares them against the DUT, with a second queue for
//   claim responses popped on each claim_valid pulse.
// ---------------------------------------------------------------------------
module tb_irq_gateway_arbiter;

  localparam int unsigned NUM_SRC = 4;
  localparam int unsigned PRIO_W  = 2;
  localparam int unsigned ID_W    = 3;

  logic                      clk = 1'b0;
  logic                      reset;
  logic [NUM_SRC-1:0]        irq_sync;
  logic [NUM_SRC*PRIO_W-1:0] src_prio;
  logic [PRIO_W-1:0]         threshold;
  logic                      claim;
  logic                      complete;
  logic [ID_W-1:0]           complete_id;
  logic                      irq_out;
  logic [ID_W-1:0]           best_id;
  logic [ID_W-1:0]           claim_id;
  logic                      claim_valid;

  always #5 clk = ~clk;

  irq_gateway_arbiter #(
    .NUM_SRC (NUM_SRC),
    .PRIO_W  (PRIO_W),
    .ID_W    (ID_W)
  ) dut (
    .i_clock       (clk),
    .i_reset       (reset),
    .i_irq_sync    (irq_sync),
    .i_src_prio    (src_prio),
    .i_threshold   (threshold),
    .i_claim       (claim),
    .i_complete    (complete),
    .i_complete_id (complete_id),
    .o_irq_out     (irq_out),
    .o_best_id     (best_id),
    .o_claim_id    (claim_id),
    .o_claim_valid (claim_valid)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int              due;
    logic            irq;
    logic [ID_W-1:0] best;
    logic [ID_W-1:0] cid;
    logic            cv;
  } exp_t;

  typedef struct {
    int              due;
    logic [ID_W-1:0] id;
  } clm_t;

  exp_t exp_q[$];
  clm_t clm_q[$];

  // Reference model state.
  bit              m_pend [NUM_SRC];
  bit              m_infl [NUM_SRC];
  logic [ID_W-1:0] m_claim_id;

  task automatic check(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  function automatic int prio_of(input logic [NUM_SRC*PRIO_W-1:0] p, input int id);
    return int'(p[(id-1)*PRIO_W +: PRIO_W]);
  endfunction

  // Highest priority level first, then lowest ID within that level.
  function automatic int winner(input logic [NUM_SRC*PRIO_W-1:0] p);
    for (int lvl = (1 << PRIO_W) - 1; lvl >= 1; lvl--) begin
      for (int id = 1; id <= int'(NUM_SRC); id++) begin
        if (m_pend[id-1] && prio_of(p, id) == lvl) return id;
      end
    end
    return 0;
  endfunction

  // Apply one cycle of inputs, advance the model, queue the prediction.
  task automatic step(input bit rst, input logic [3:0] irq, input logic [7:0] prio,
                      input logic [1:0] thr, input bit clm, input bit cmp,
                      input logic [2:0] cid);
    exp_t e;
    int   w;
    bit   idle0 [NUM_SRC];
    bit   infl0 [NUM_SRC];
    reset = rst; irq_sync = irq; src_prio = prio; threshold = thr;
    claim = clm; complete = cmp; complete_id = cid;
    e.due = cyc + 1;
    if (rst) begin
      for (int i = 0; i < int'(NUM_SRC); i++) begin
        m_pend[i] = 0;
        m_infl[i] = 0;
      end
      m_claim_id = '0;
      e.irq = 0; e.best = '0; e.cid = '0; e.cv = 0;
    end else begin
      for (int i = 0; i < int'(NUM_SRC); i++) begin
        idle0[i] = !m_pend[i] && !m_infl[i];
        infl0[i] = m_infl[i];
      end
      w = winner(prio);
      e.best = ID_W'(w);
      e.irq  = (w != 0) ? (prio_of(prio, w) > int'(thr)) : 1'b0;
      e.cv   = clm;
      if (cmp && cid >= 1 && cid <= NUM_SRC && infl0[cid-1]) m_infl[cid-1] = 0;
      if (clm) begin
        m_claim_id = ID_W'(w);
        clm_q.push_back('{cyc + 1, ID_W'(w)});
        if (w != 0) begin
          m_pend[w-1] = 0;
          m_infl[w-1] = 1;
        end
      end
      for (int i = 0; i < int'(NUM_SRC); i++) begin
        if (idle0[i] && irq[i]) m_pend[i] = 1;
      end
      e.cid = m_claim_id;
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every due prediction, and each claim pulse.
  always @(negedge clk) begin
    exp_t e;
    clm_t c;
    while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
      e = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL stale_prediction: got cycle %0d expected cycle %0d", cyc, e.due);
    end
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      e = exp_q.pop_front();
      check("irq_out", int'(irq_out), int'(e.irq));
      check("best_id", int'(best_id), int'(e.best));
      check("claim_id_hold", int'(claim_id), int'(e.cid));
      check("claim_valid", int'(claim_valid), int'(e.cv));
    end
    if (claim_valid === 1'b1) begin
      if (clm_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_claim_valid: got 1 expected 0 (cycle %0d)", cyc);
      end else begin
        c = clm_q.pop_front();
        check("claim_resp_id", int'(claim_id), int'(c.id));
        check("claim_resp_cycle", cyc, c.due);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  localparam logic [7:0] P1 = 8'b01_01_01_01;

  initial begin
    logic [7:0] r_prio;
    logic [1:0] r_thr;
    logic [3:0] r_irq;
    logic [2:0] r_cid;
    bit         r_cmp;

    // Reset state.
    step(1, 4'b0000, P1, 2'd0, 0, 0, 3'd0);
    step(1, 4'b0000, P1, 2'd0, 1, 1, 3'd1);
    check("rst_irq_out", int'(irq_out), 0);
    check("rst_best_id", int'(best_id), 0);
    check("rst_claim_valid", int'(claim_valid), 0);

    // Single source: 2-cycle latency, claim, then irq drops.
    step(0, 4'b0010, P1, 2'd0, 0, 0, 3'd0);
    check("t1_irq_cycle1", int'(irq_out), 0);
    step(0, 4'b0010, P1, 2'd0, 0, 0, 3'd0);
    check("t1_irq_cycle2", int'(irq_out), 1);
    check("t1_best_cycle2", int'(best_id), 2);
    step(0, 4'b0010, P1, 2'd0, 1, 0, 3'd0);
    check("t1_claim_id", int'(claim_id), 2);
    check("t1_claim_valid", int'(claim_valid), 1);
    step(0, 4'b0000, P1, 2'd0, 0, 0, 3'd0);
    check("t1_irq_after", int'(irq_out), 0);
    check("t1_pulse_end", int'(claim_valid), 0);
    step(0, 4'b0000, P1, 2'd0, 0, 1, 3'd2);

    // Priority order and tie-break.
    step(0, 4'b0101, 8'b01_11_01_10, 2'd0, 0, 0, 3'd0);
    step(0, 4'b0000, 8'b01_11_01_10, 2'd0, 0, 0, 3'd0);
    check("t2_best_hi", int'(best_id), 3);
    step(0, 4'b0000, 8'b01_10_01_10, 2'd0, 0, 0, 3'd0);
    check("t2_best_tie", int'(best_id), 1);
    step(0, 4'b0000, 8'b01_10_01_00, 2'd0, 0, 0, 3'd0);
    check("t2_best_dis", int'(best_id), 3);

    // Threshold gates irq_out but not claim.
    step(1, 4'b0000, 8'b10_00_00_00, 2'd2, 0, 0, 3'd0);
    step(0, 4'b1000, 8'b10_00_00_00, 2'd2, 0, 0, 3'd0);
    step(0, 4'b1000, 8'b10_00_00_00, 2'd2, 0, 0, 3'd0);
    check("t3_irq_thr", int'(irq_out), 0);
    check("t3_best", int'(best_id), 4);
    step(0, 4'b0000, 8'b10_00_00_00, 2'd2, 1, 0, 3'd0);
    check("t3_claim_id", int'(claim_id), 4);
    step(0, 4'b0000, 8'b10_00_00_00, 2'd2, 0, 1, 3'd4);

    // No re-pend in flight; completion re-pends after 2 cycles.
    step(1, 4'b0000, P1, 2'd0, 0, 0, 3'd0);
    step(0, 4'b0010, P1, 2'd0, 0, 0, 3'd0);
    step(0, 4'b0010, P1, 2'd0, 0, 0, 3'd0);
    step(0, 4'b0010, P1, 2'd0, 1, 0, 3'd0);
    step(0, 4'b0010, P1, 2'd0, 0, 0, 3'd0);
    step(0, 4'b0010, P1, 2'd0, 0, 0, 3'd0);
    check("t4_no_repend", int'(best_id), 0);
    step(0, 4'b0010, P1, 2'd0, 0, 1, 3'd2);
    step(0, 4'b0010, P1, 2'd0, 0, 0, 3'd0);
    check("t4_repend_c1", int'(irq_out), 0);
    step(0, 4'b0010, P1, 2'd0, 0, 0, 3'd0);
    check("t4_repend_c2", int'(irq_out), 1);

    // Invalid complete, then claim and complete together.
    step(0, 4'b0010, P1, 2'd0, 0, 1, 3'd5);
    check("t5_bad_cid", int'(best_id), 2);
    step(0, 4'b0010, P1, 2'd0, 1, 0, 3'd0);
    step(0, 4'b0011, P1, 2'd0, 0, 0, 3'd0);
    step(0, 4'b0011, P1, 2'd0, 1, 1, 3'd2);
    check("t5_claim_cmp", int'(claim_id), 1);
    step(0, 4'b0011, P1, 2'd0, 0, 0, 3'd0);
    step(0, 4'b0011, P1, 2'd0, 0, 0, 3'd0);
    check("t5_src2_back", int'(best_id), 2);

    // Reset mid-handshake (src1 in flight, src2 pending), empty claim.
    step(1, 4'b0011, P1, 2'd0, 1, 1, 3'd1);
    check("t6_rst_irq", int'(irq_out), 0);
    check("t6_rst_best", int'(best_id), 0);
    check("t6_rst_cid", int'(claim_id), 0);
    step(0, 4'b0000, P1, 2'd0, 1, 0, 3'd0);
    check("t6_empty_cid", int'(claim_id), 0);
    check("t6_empty_cv", int'(claim_valid), 1);
    step(0, 4'b0011, P1, 2'd0, 0, 0, 3'd0);
    step(0, 4'b0011, P1, 2'd0, 0, 0, 3'd0);
    check("t6_repend", int'(best_id), 1);

    // Random traffic.
    r_prio = P1;
    r_thr  = 2'd0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 39) == 0) r_prio = 8'($urandom);
      if ($urandom_range(0, 59) == 0) r_thr = 2'($urandom);
      r_irq = 4'($urandom) & 4'($urandom);
      r_cmp = ($urandom_range(0, 2) == 0);
      r_cid = ($urandom_range(0, 4) == 0) ? 3'($urandom) : 3'($urandom_range(1, 4));
      step($urandom_range(0, 149) == 0, r_irq, r_prio, r_thr,
           $urandom_range(0, 3) == 0, r_cmp, r_cid);
    end

    step(0, 4'b0000, r_prio, r_thr, 0, 0, 3'd0);
    @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0 || clm_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d/%0d queued expected 0/0", exp_q.size(), clm_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
